// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM read-port arbiter: FSM encoding and
// the round-robin search used by the priority picker.
package dram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESPOND
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int MAX_REQ         = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping modulo n (n <= MAX_REQ).
    // Iterating downward lets the nearest candidate overwrite farther ones.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                cand = int'(ptr) + k;
                if (cand >= n) cand = cand - n;
                if (req[3'(cand)]) begin
                    res.found = 1'b1;
                    res.idx   = 3'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-find-first over NUM_REQ request bits.
module rr_priority_picker
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    grant_idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         ptr_ext;
    rr_pick_t           pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = ptr;
        pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
    end

    assign found     = pick.found;
    assign grant_idx = ID_W'(pick.idx);

endmodule

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter/sequencer sharing the DRAM controller read port among
// NUM_REQ requesters, with busy/valid tracking and a per-wait-state watchdog.
module dram_read_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int DRAM_DATA_WIDTH = 512,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT,
    parameter int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_areset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]              req_len,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              rsp_valid,
    output logic [ID_W-1:0]                   rsp_id,
    output logic [DRAM_DATA_WIDTH-1:0]        rsp_data,
    output logic                              rsp_error,
    output logic [AXI_ADDR_WIDTH-1:0]         dram_read_addr,
    output logic [7:0]                        dram_read_len,
    output logic                              dram_read_en,
    input  logic [DRAM_DATA_WIDTH-1:0]        dram_read_data,
    input  logic                              dram_read_data_valid,
    input  logic                              dram_read_busy
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [WD_W-1:0] wdog;
    logic [WD_W-1:0] wd_inc;
    logic            wd_hit;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] rr_next;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .found     (pick_found),
        .grant_idx (pick_idx)
    );

    // Saturating increment; hitting the limit on this cycle ends the wait.
    always_comb begin
        wd_inc  = (wdog == WD_MAX) ? wdog : wdog + 1'b1;
        wd_hit  = (wd_inc == WD_MAX);
        rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            grant_id       <= '0;
            wdog           <= '0;
            req_ready      <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
            dram_read_en   <= 1'b0;
            dram_read_addr <= '0;
            dram_read_len  <= '0;
        end else begin
            req_ready    <= '0;
            dram_read_en <= 1'b0;
            rsp_valid    <= 1'b0;
            unique case (state)
                // Busy gate also keeps us off a controller still finishing an
                // orphaned read after reset.
                ST_IDLE: if (pick_found && !dram_read_busy) begin
                    grant_id       <= pick_idx;
                    dram_read_addr <= req_addr[pick_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    dram_read_len  <= req_len[pick_idx*8 +: 8];
                    dram_read_en   <= 1'b1;
                    req_ready      <= NUM_REQ'(1) << pick_idx;
                    state          <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    wdog   <= '0;
                    rr_ptr <= rr_next;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (dram_read_busy) begin
                        wdog  <= '0;
                        state <= ST_WAIT_DONE;
                    end else begin
                        wdog <= wd_inc;
                        if (wd_hit) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= grant_id;
                            rsp_data  <= '0;
                            rsp_error <= 1'b1;
                            state     <= ST_RESPOND;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    wdog <= wd_inc;
                    if (dram_read_data_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= grant_id;
                        rsp_data  <= dram_read_data;
                        rsp_error <= 1'b0;
                        state     <= ST_RESPOND;
                    end else if (!dram_read_busy || wd_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= grant_id;
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        state     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed bench for dram_read_arbiter: stimulus pushes expected issues and
// responses into queues, a negedge monitor pops and compares them.
module tb_dram_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int TO = 16;

    logic              m_axi_aclk = 1'b0;
    logic              m_axi_areset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*8-1:0]   req_len = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_error;
    logic [AW-1:0]     dram_read_addr;
    logic [7:0]        dram_read_len;
    logic              dram_read_en;
    logic [DW-1:0]     dram_read_data = '0;
    logic              dram_read_data_valid = 1'b0;
    logic              dram_read_busy = 1'b0;

    dram_read_arbiter #(
        .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .dram_read_addr(dram_read_addr), .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
        .dram_read_data(dram_read_data), .dram_read_data_valid(dram_read_data_valid),
        .dram_read_busy(dram_read_busy)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    typedef struct { int id; logic [DW-1:0] data; int err; } rsp_t;
    typedef struct { int id; logic [AW-1:0] addr; logic [7:0] len; } iss_t;

    rsp_t exp_rsp[$];
    iss_t exp_iss[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge m_axi_aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every issue and every response must match the head of its queue.
    always @(negedge m_axi_aclk) begin : mon
        rsp_t r;
        iss_t s;
        if (!m_axi_areset) begin
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", longint'(rsp_valid), 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_id", longint'(rsp_id), r.id);
                    chk("rsp_error", longint'(rsp_error), r.err);
                    chk_data("rsp_data", rsp_data, r.data);
                end
            end
            if (dram_read_en) begin
                if (exp_iss.size() == 0) chk("issue_unexpected", longint'(dram_read_en), 0);
                else begin
                    s = exp_iss.pop_front();
                    chk("req_ready_onehot", longint'(req_ready), longint'(1) << s.id);
                    chk("dram_read_addr", longint'(dram_read_addr), longint'(s.addr));
                    chk("dram_read_len", longint'(dram_read_len), longint'(s.len));
                end
            end else if (req_ready != '0) begin
                chk("ready_without_en", longint'(req_ready), 0);
            end
        end
    end

    task automatic tick;
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic wait_en(output int t);
        int n = 0;
        do begin @(negedge m_axi_aclk); n++; end while (!dram_read_en && n < 60);
        chk("issue_seen", longint'(dram_read_en), 1);
        t = cyc;
    endtask

    task automatic wait_rsp(output int t);
        int n = 0;
        do begin @(negedge m_axi_aclk); n++; end while (!rsp_valid && n < 60);
        chk("rsp_seen", longint'(rsp_valid), 1);
        t = cyc;
    endtask

    task automatic set_req(input int id, input logic [AW-1:0] a, input logic [7:0] l);
        req_addr[id*AW +: AW] = a;
        req_len[id*8 +: 8]    = l;
        req_valid[id]         = 1'b1;
    endtask

    task automatic expect_txn(input int id, input logic [AW-1:0] a, input logic [7:0] l,
                              input logic [DW-1:0] d, input int err);
        exp_iss.push_back('{id: id, addr: a, len: l});
        exp_rsp.push_back('{id: id, data: (err != 0) ? '0 : d, err: err});
    endtask

    // Controller model, entered in the cycle after the issue cycle.
    // 0: busy 3 cycles, valid on the 3rd; 1: busy drops with no valid;
    // 2: busy never rises; 3: busy stuck high (caller releases it).
    task automatic ctrl(input int mode, input logic [DW-1:0] d);
        case (mode)
            0: begin
                dram_read_busy = 1'b1; tick; tick;
                dram_read_data_valid = 1'b1; dram_read_data = d; tick;
                dram_read_data_valid = 1'b0; dram_read_busy = 1'b0; dram_read_data = '0;
            end
            1: begin
                dram_read_busy = 1'b1; dram_read_data = {64{8'h5A}}; tick; tick;
                dram_read_busy = 1'b0; dram_read_data = '0;
            end
            3: dram_read_busy = 1'b1;
            default: ;
        endcase
    endtask

    task automatic txn(input int id, input logic [AW-1:0] a, input logic [7:0] l,
                       input int mode, input logic [DW-1:0] d, input int lat);
        int te, tr;
        expect_txn(id, a, l, d, (mode != 0) ? 1 : 0);
        set_req(id, a, l);
        wait_en(te);
        tick;
        req_valid[id] = 1'b0;
        ctrl(mode, d);
        wait_rsp(tr);
        chk("rsp_latency", tr - te, lat);
        tick;
        dram_read_busy = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, longint'(req_ready), 0);
        chk({tag, "_rsp_valid"}, longint'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, longint'(rsp_id), 0);
        chk({tag, "_rsp_error"}, longint'(rsp_error), 0);
        chk_data({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_en"}, longint'(dram_read_en), 0);
        chk({tag, "_addr"}, longint'(dram_read_addr), 0);
        chk({tag, "_len"}, longint'(dram_read_len), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] d;
        int te, tr, tfall;
        int order[2];
        a5 = {64{8'hA5}};

        repeat (3) tick;
        m_axi_areset = 1'b0;
        @(negedge m_axi_aclk);
        chk_outputs_zero("reset");

        // Fairness: all four held high, expect 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            d = {16{32'hC0DE_0000 + 32'(k)}};
            expect_txn(k % 4, 32'h2000_0000 + 32'((k % 4) * 256), 8'((k % 4) + 1), d, 0);
        end
        for (int i = 0; i < 4; i++) set_req(i, 32'h2000_0000 + 32'(i * 256), 8'(i + 1));
        for (int k = 0; k < 8; k++) begin
            wait_en(te);
            tick;
            ctrl(0, {16{32'hC0DE_0000 + 32'(k)}});
            wait_rsp(tr);
            chk("fair_latency", tr - te, 4);
            tick;
            if (k == 7) req_valid = '0;
        end
        tick;

        // Single request, hand-computed expectations.
        txn(2, 32'h1000_0040, 8'd0, 0, a5, 4);
        // Controller error, then normal service.
        txn(1, 32'h0000_8000, 8'd3, 1, a5, 4);
        txn(3, 32'h3000_0100, 8'd7, 0, {8{64'h0123_4567_89AB_CDEF}}, 4);
        // Hangs: 1 issue cycle + 16 in WAIT_BUSY; 1 + 1 + 16 via WAIT_DONE.
        txn(0, 32'h4000_0000, 8'd15, 2, a5, 1 + TO);
        txn(1, 32'h5000_0000, 8'd1, 3, a5, 2 + TO);
        tick;

        // Busy gate: no issue while busy, issue the cycle after it falls.
        d = {64{8'h3C}};
        dram_read_busy = 1'b1;
        expect_txn(1, 32'h6000_0080, 8'd2, d, 0);
        set_req(1, 32'h6000_0080, 8'd2);
        repeat (5) begin
            @(negedge m_axi_aclk);
            chk("busy_gate_hold", longint'(dram_read_en), 0);
        end
        tick;
        dram_read_busy = 1'b0;
        tfall = cyc;
        wait_en(te);
        chk("busy_gate_issue_cycle", te, tfall + 1);
        tick;
        req_valid[1] = 1'b0;
        ctrl(0, d);
        wait_rsp(tr);
        tick; tick;

        // Reset in WAIT_DONE: no response, orphan valid ignored, rr_ptr back to 0.
        exp_iss.push_back('{id: 2, addr: 32'h7000_0000, len: 8'd4});
        set_req(2, 32'h7000_0000, 8'd4);
        wait_en(te);
        tick;
        req_valid[2] = 1'b0;
        dram_read_busy = 1'b1;
        tick;
        m_axi_areset = 1'b1;
        tick;
        m_axi_areset = 1'b0;
        @(negedge m_axi_aclk);
        chk_outputs_zero("midreset");
        tick;
        dram_read_data_valid = 1'b1;
        dram_read_data = {64{8'hEE}};
        tick;
        dram_read_data_valid = 1'b0;
        dram_read_busy = 1'b0;
        dram_read_data = '0;
        repeat (4) begin
            @(negedge m_axi_aclk);
            chk("orphan_no_rsp", longint'(rsp_valid), 0);
        end
        tick;
        order[0] = 0;
        order[1] = 3;
        for (int k = 0; k < 2; k++)
            expect_txn(order[k], 32'h8000_0000 + 32'(order[k]), 8'(order[k]), {64{8'(k + 1)}}, 0);
        set_req(0, 32'h8000_0000, 8'd0);
        set_req(3, 32'h8000_0003, 8'd3);
        for (int k = 0; k < 2; k++) begin
            wait_en(te);
            tick;
            req_valid[order[k]] = 1'b0;
            ctrl(0, {64{8'(k + 1)}});
            wait_rsp(tr);
            tick;
        end
        repeat (3) tick;

        chk("issue_queue_drained", exp_iss.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
